// File: rtl/bp_pkg.sv
// Shared BytePipe definitions: byte width, command-byte layout and the
// initiator state encoding.
package bp_pkg;

  localparam int         BP_BYTE_W     = 8;
  localparam int         BP_CMD_WR     = 7;
  localparam logic [6:0] BP_ADDR_BURST = 7'd0;

  typedef logic [BP_BYTE_W-1:0] bp_byte_t;

  // Burst-set is a write to the reserved address 0.
  localparam bp_byte_t BP_BURST_SET = {1'b1, BP_ADDR_BURST};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_CMD,
    ST_SET_LEN,
    ST_SET_RSP,
    ST_CMD,
    ST_WDATA,
    ST_RSP
  } bp_state_t;

  function automatic bp_byte_t bp_cmd_byte(input logic wr, input logic [6:0] addr);
    bp_byte_t b;
    b            = {1'b0, addr};
    b[BP_CMD_WR] = wr;
    return b;
  endfunction

endpackage

// File: rtl/bp_initiator.sv
// BytePipe initiator: turns register read/write/burst requests into the
// BytePipe byte stream and forwards the responder's reply bytes.
module bp_initiator
  import bp_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cg,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_wr,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_len,
  input  logic [7:0] i_wdata,
  input  logic       i_wdata_valid,
  output logic       o_wdata_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_valid,
  output logic       o_rsp_last,
  output logic       o_rsp_err,
  input  logic       i_rsp_ready,
  output logic [7:0] o_bp_data,
  output logic       o_bp_valid,
  input  logic       i_bp_ready,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready
);

  localparam logic [15:0] WDOG_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  bp_state_t   state_reg, state_next;
  logic        wr_reg, wr_next;
  logic [6:0]  addr_reg, addr_next;
  bp_byte_t    len_reg, len_next;
  bp_byte_t    beat_reg, beat_next;
  logic [15:0] wdog_reg, wdog_next;
  bp_byte_t    bp_data_reg, bp_data_next;
  logic        bp_valid_reg, bp_valid_next;
  logic        err_reg, err_next;

  // Write data bypasses the output register so a byte moves every cycle.
  assign o_req_ready   = (state_reg == ST_IDLE);
  assign o_bp_data     = (state_reg == ST_WDATA) ? i_wdata : bp_data_reg;
  assign o_bp_valid    = (state_reg == ST_WDATA) ? i_wdata_valid : bp_valid_reg;
  assign o_wdata_ready = (state_reg == ST_WDATA) && i_bp_ready;
  assign o_bp_ready    = (state_reg == ST_RSP) ? i_rsp_ready : 1'b1;
  assign o_rsp_data    = (state_reg == ST_RSP) ? i_bp_data : 8'h00;
  assign o_rsp_valid   = (state_reg == ST_RSP) && i_bp_valid;
  assign o_rsp_last    = (state_reg == ST_RSP) && i_bp_valid && (beat_reg == 8'd0);
  assign o_rsp_err     = err_reg;

  always_comb begin
    state_next    = state_reg;
    wr_next       = wr_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    beat_next     = beat_reg;
    bp_data_next  = bp_data_reg;
    bp_valid_next = bp_valid_reg;
    err_next      = 1'b0;
    wdog_next     = 16'd0;

    case (state_reg)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (i_req_addr == BP_ADDR_BURST) begin
            err_next = 1'b1;
          end else begin
            wr_next       = i_req_wr;
            addr_next     = i_req_addr;
            len_next      = i_req_len;
            bp_valid_next = 1'b1;
            if (i_req_len != 8'd0) begin
              bp_data_next = BP_BURST_SET;
              state_next   = ST_SET_CMD;
            end else begin
              bp_data_next = bp_cmd_byte(i_req_wr, i_req_addr);
              state_next   = ST_CMD;
            end
          end
        end
      end
      ST_SET_CMD: begin
        if (i_bp_ready) begin
          bp_data_next = len_reg;
          state_next   = ST_SET_LEN;
        end
      end
      ST_SET_LEN: begin
        if (i_bp_ready) begin
          bp_valid_next = 1'b0;
          state_next    = ST_SET_RSP;
        end
      end
      ST_SET_RSP: begin
        if (i_bp_valid) begin
          bp_data_next  = bp_cmd_byte(wr_reg, addr_reg);
          bp_valid_next = 1'b1;
          state_next    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (i_bp_ready) begin
          bp_valid_next = 1'b0;
          beat_next     = len_reg;
          state_next    = wr_reg ? ST_WDATA : ST_RSP;
        end
      end
      ST_WDATA: begin
        // A write always ends with exactly one reply, so the count stays at 0.
        if (i_wdata_valid && i_bp_ready) begin
          if (beat_reg == 8'd0) state_next = ST_RSP;
          else                  beat_next  = beat_reg - 8'd1;
        end
      end
      ST_RSP: begin
        if (i_bp_valid && i_rsp_ready) begin
          if (beat_reg == 8'd0) state_next = ST_IDLE;
          else                  beat_next  = beat_reg - 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Watchdog only runs while waiting on the responder with nothing offered.
    if ((TIMEOUT != 0) && !i_bp_valid && (state_next == state_reg) &&
        ((state_reg == ST_SET_RSP) || (state_reg == ST_RSP))) begin
      if (wdog_reg == WDOG_LAST) begin
        state_next    = ST_IDLE;
        err_next      = 1'b1;
        beat_next     = 8'd0;
        bp_valid_next = 1'b0;
      end else begin
        wdog_next = wdog_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      wr_reg       <= 1'b0;
      addr_reg     <= 7'd0;
      len_reg      <= 8'd0;
      beat_reg     <= 8'd0;
      wdog_reg     <= 16'd0;
      bp_data_reg  <= 8'd0;
      bp_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else if (i_cg) begin
      state_reg    <= state_next;
      wr_reg       <= wr_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_reg     <= beat_next;
      wdog_reg     <= wdog_next;
      bp_data_reg  <= bp_data_next;
      bp_valid_reg <= bp_valid_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: tb/tb_bp_initiator.sv
// Directed bench for bp_initiator with a small BytePipe responder model on
// the far side of the link.
module tb_bp_initiator;
  import bp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cg = 1'b1;
  logic       i_req_valid = 1'b0, o_req_ready, i_req_wr = 1'b0;
  logic [6:0] i_req_addr = 7'd0;
  logic [7:0] i_req_len = 8'd0;
  logic [7:0] i_wdata = 8'd0;
  logic       i_wdata_valid = 1'b0, o_wdata_ready;
  logic [7:0] o_rsp_data;
  logic       o_rsp_valid, o_rsp_last, o_rsp_err;
  logic       i_rsp_ready = 1'b1;
  logic [7:0] o_bp_data;
  logic       o_bp_valid, o_bp_ready;
  logic       i_bp_ready = 1'b1;
  logic [7:0] i_bp_data = 8'd0;
  logic       i_bp_valid = 1'b0;

  always #5 clk = ~clk;

  bp_initiator #(.TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .o_rsp_last(o_rsp_last),
    .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready),
    .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
    .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder model state
  logic [7:0] regs [128];
  bit   [7:0] tx_q[$];
  int         rs_state = 0;
  int         burst_len = 0;
  logic [6:0] wr_addr = 7'd0;
  int         wr_left = 0;
  logic [7:0] wr_prev = 8'd0;
  bit         rs_silent = 1'b0;

  // Initiator-side stimulus and logs
  bit   [7:0] wd_q[$];
  bit   [7:0] bp_log[$];
  bit   [7:0] rsp_log[$];
  bit   [7:0] exp_q[$];
  int         last_mask, err_cnt, err_cyc, bp_cyc;
  int         cyc = 0;
  bit         got_last, gap_mode = 1'b0, toggle_rsp = 1'b0, bp_rdy = 1'b1;

  task automatic rs_push(input logic [7:0] b);
    if (!rs_silent) tx_q.push_back(b);
  endtask

  task automatic rs_feed(input logic [7:0] b);
    case (rs_state)
      0: begin
        if (b == 8'h80) begin
          rs_state = 1;
        end else if (b[7]) begin
          wr_addr  = b[6:0];
          wr_left  = burst_len + 1;
          wr_prev  = regs[b[6:0]];
          rs_state = 2;
        end else begin
          for (int i = 0; i <= burst_len; i++) rs_push(regs[b[6:0]]);
          burst_len = 0;
        end
      end
      1: begin
        burst_len = int'(b);
        rs_push(8'h5A);
        rs_state = 0;
      end
      default: begin
        regs[wr_addr] = b;
        wr_left--;
        if (wr_left == 0) begin
          rs_push(wr_prev);
          burst_len = 0;
          rs_state  = 0;
        end
      end
    endcase
  endtask

  task automatic drive();
    i_bp_valid    = (tx_q.size() > 0);
    i_bp_data     = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    i_wdata_valid = (wd_q.size() > 0) && (!gap_mode || (cyc % 3 != 0));
    i_wdata       = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
    i_bp_ready    = bp_rdy;
    if (toggle_rsp) i_rsp_ready = ~i_rsp_ready;
  endtask

  // One clock: sample handshakes mid-cycle, then apply their effects after the edge.
  task automatic tick();
    logic bp_hs, rin_hs, rsp_hs, wd_hs, req_hs, rsp_l;
    logic [7:0] bp_b, rsp_b;
    int c0;
    @(negedge clk);
    c0     = cyc;
    bp_hs  = cg && rst_n && o_bp_valid && i_bp_ready;
    bp_b   = o_bp_data;
    rin_hs = cg && rst_n && i_bp_valid && o_bp_ready;
    rsp_hs = cg && rst_n && o_rsp_valid && i_rsp_ready;
    rsp_b  = o_rsp_data;
    rsp_l  = o_rsp_last;
    wd_hs  = cg && rst_n && i_wdata_valid && o_wdata_ready;
    req_hs = cg && rst_n && i_req_valid && o_req_ready;
    if (o_rsp_err) begin
      err_cnt++;
      err_cyc = c0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (req_hs) i_req_valid = 1'b0;
    if (wd_hs)  void'(wd_q.pop_front());
    if (rin_hs) void'(tx_q.pop_front());
    if (rsp_hs) begin
      if (rsp_l) begin
        last_mask |= (1 << rsp_log.size());
        got_last = 1'b1;
      end
      rsp_log.push_back(rsp_b);
    end
    if (bp_hs) begin
      bp_log.push_back(bp_b);
      bp_cyc = c0;
      rs_feed(bp_b);
    end
    drive();
  endtask

  task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] len);
    bp_log.delete();
    rsp_log.delete();
    last_mask   = 0;
    err_cnt     = 0;
    got_last    = 1'b0;
    i_req_wr    = wr;
    i_req_addr  = addr;
    i_req_len   = len;
    i_req_valid = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(got_last || err_cnt > 0) && n < 400) begin
      tick();
      n++;
    end
    check_eq({name, "_done"}, 32'(got_last || err_cnt > 0), 1);
    $display("txn %s: %0d bytes sent, %0d reply bytes, err=%0d, cycles=%0d",
             name, bp_log.size(), rsp_log.size(), err_cnt, n);
  endtask

  task automatic check_bytes(input string tag, input bit [7:0] got[$], input bit [7:0] exp[$]);
    check_eq({tag, "_cnt"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[5] = 8'hA5; regs[3] = 8'h11; regs[7] = 8'h77; regs[2] = 8'h22; regs[9] = 8'h99;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", o_req_ready, 1);
    check_eq("rst_bp_valid", o_bp_valid, 0);
    check_eq("rst_rsp_valid", o_rsp_valid, 0);
    check_eq("rst_rsp_last", o_rsp_last, 0);
    check_eq("rst_rsp_err", o_rsp_err, 0);
    check_eq("rst_wdata_ready", o_wdata_ready, 0);
    check_eq("rst_bp_ready", o_bp_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single read
    issue(1'b0, 7'h05, 8'd0);
    wait_done("rd05");
    exp_q = '{8'h05};               check_bytes("rd05_bp", bp_log, exp_q);
    exp_q = '{8'hA5};               check_bytes("rd05_rsp", rsp_log, exp_q);
    check_eq("rd05_last", last_mask, 1);
    check_eq("rd05_idle", o_req_ready, 1);

    // Single write, then read back
    wd_q = '{8'h3C};
    issue(1'b1, 7'h03, 8'd0);
    wait_done("wr03");
    exp_q = '{8'h83, 8'h3C};        check_bytes("wr03_bp", bp_log, exp_q);
    exp_q = '{8'h11};               check_bytes("wr03_rsp", rsp_log, exp_q);
    check_eq("wr03_last", last_mask, 1);
    issue(1'b0, 7'h03, 8'd0);
    wait_done("rb03");
    exp_q = '{8'h3C};               check_bytes("rb03_rsp", rsp_log, exp_q);

    // Burst read, 4 beats
    issue(1'b0, 7'h07, 8'd3);
    wait_done("brd07");
    exp_q = '{8'h80, 8'h03, 8'h07}; check_bytes("brd07_bp", bp_log, exp_q);
    exp_q = '{8'h77, 8'h77, 8'h77, 8'h77};
    check_bytes("brd07_rsp", rsp_log, exp_q);
    check_eq("brd07_last", last_mask, 8);

    // Burst write, 3 beats
    wd_q = '{8'h01, 8'h02, 8'h03};
    issue(1'b1, 7'h02, 8'd2);
    wait_done("bwr02");
    exp_q = '{8'h80, 8'h02, 8'h82, 8'h01, 8'h02, 8'h03};
    check_bytes("bwr02_bp", bp_log, exp_q);
    exp_q = '{8'h22};               check_bytes("bwr02_rsp", rsp_log, exp_q);
    check_eq("bwr02_last", last_mask, 1);
    issue(1'b0, 7'h02, 8'd0);
    wait_done("rb02");
    exp_q = '{8'h03};               check_bytes("rb02_rsp", rsp_log, exp_q);

    // Same burst write with write-data gaps and a stuttering reply sink
    gap_mode = 1'b1;
    toggle_rsp = 1'b1;
    wd_q = '{8'h04, 8'h05, 8'h06};
    issue(1'b1, 7'h02, 8'd2);
    wait_done("bwr02s");
    exp_q = '{8'h80, 8'h02, 8'h82, 8'h04, 8'h05, 8'h06};
    check_bytes("bwr02s_bp", bp_log, exp_q);
    exp_q = '{8'h03};               check_bytes("bwr02s_rsp", rsp_log, exp_q);
    issue(1'b0, 7'h02, 8'd2);
    wait_done("brd02s");
    exp_q = '{8'h06, 8'h06, 8'h06}; check_bytes("brd02s_rsp", rsp_log, exp_q);
    check_eq("brd02s_last", last_mask, 4);
    gap_mode = 1'b0;
    toggle_rsp = 1'b0;
    i_rsp_ready = 1'b1;
    tick();

    // Address 0 is rejected with a single error pulse and no link traffic
    issue(1'b0, 7'h00, 8'd0);
    wait_done("rd00");
    repeat (3) tick();
    check_eq("rd00_err_cnt", err_cnt, 1);
    check_eq("rd00_bp_cnt", bp_log.size(), 0);
    check_eq("rd00_idle", o_req_ready, 1);

    // Silent responder: abort 16 edges after the command handshake edge,
    // which is 17 sample points with this bench's cycle numbering
    rs_silent = 1'b1;
    issue(1'b0, 7'h09, 8'd0);
    wait_done("tmo09");
    repeat (3) tick();
    check_eq("tmo09_delay", err_cyc - bp_cyc, 17);
    check_eq("tmo09_err_cnt", err_cnt, 1);
    check_eq("tmo09_rsp_cnt", rsp_log.size(), 0);
    check_eq("tmo09_idle", o_req_ready, 1);
    rs_silent = 1'b0;

    // Clock gate low freezes a presented command byte
    bp_rdy = 1'b0;
    issue(1'b0, 7'h05, 8'd0);
    tick();
    tick();
    check_eq("cg_cmd_valid", o_bp_valid, 1);
    check_eq("cg_cmd_data", o_bp_data, 8'h05);
    cg = 1'b0;
    bp_rdy = 1'b1;
    repeat (3) tick();
    check_eq("cg_hold_valid", o_bp_valid, 1);
    check_eq("cg_hold_busy", o_req_ready, 0);
    check_eq("cg_hold_bp_cnt", bp_log.size(), 0);
    cg = 1'b1;
    wait_done("cg05");
    exp_q = '{8'hA5};               check_bytes("cg05_rsp", rsp_log, exp_q);

    // Reset in the middle of a burst write
    gap_mode = 1'b1;
    wd_q = '{8'h01, 8'h02, 8'h03};
    issue(1'b1, 7'h03, 8'd2);
    for (int n = 0; n < 100 && bp_log.size() < 4; n++) tick();
    check_eq("mid_bp_cnt", bp_log.size(), 4);
    check_eq("mid_busy", o_req_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req_ready", o_req_ready, 1);
    check_eq("mid_rst_bp_valid", o_bp_valid, 0);
    check_eq("mid_rst_wdata_ready", o_wdata_ready, 0);
    check_eq("mid_rst_rsp_valid", o_rsp_valid, 0);
    check_eq("mid_rst_bp_ready", o_bp_ready, 1);
    check_eq("mid_rst_rsp_err", o_rsp_err, 0);
    gap_mode = 1'b0;
    wd_q.delete();
    tx_q.delete();
    rs_state = 0;
    burst_len = 0;
    i_req_valid = 1'b0;
    tick();
    check_eq("mid_rst_hold_rsp_valid", o_rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    issue(1'b0, 7'h05, 8'd0);
    wait_done("post05");
    exp_q = '{8'h05};               check_bytes("post05_bp", bp_log, exp_q);
    exp_q = '{8'hA5};               check_bytes("post05_rsp", rsp_log, exp_q);
    check_eq("post05_last", last_mask, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
